// File: rtl/shared_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_counter_arbiter
// Purpose  : Shares one N-bit up counter between R requesters. A round-robin
//            arbiter picks a requester, loads its terminal count, runs the
//            counter from 0 up to that count and pulses the owner's done bit.
// Ports    : clk    - clock, all state changes on posedge
//            clr    - asynchronous active-high reset
//            req    - [R]   per-requester interval request, held until done
//            limit  - [R*N] flat terminal counts, limit[i*N +: N] for req i
//            gnt    - [R]   one-hot owner of the counter, 0 when idle
//            count  - [N]   current counter value
//            busy   - 1 while an interval is running or finishing
//            done   - [R]   one-cycle pulse on the owner's bit at interval end
// Revision : 1.0 - initial release
// ============================================================================
module shared_counter_arbiter #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] limit,
    output logic [R-1:0]   gnt,
    output logic [N-1:0]   count,
    output logic           busy,
    output logic [R-1:0]   done
);

    localparam int            c_iw        = (R > 1) ? $clog2(R) : 1;
    // Pointer starts on the last requester so requester 0 wins first.
    localparam logic [c_iw-1:0] c_last_init = c_iw'(R - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [R-1:0]    gnt_q,   gnt_d;
    logic [N-1:0]    count_q, count_d;
    logic            busy_q,  busy_d;
    logic [R-1:0]    done_q,  done_d;
    logic [N-1:0]    lim_q,   lim_d;     // terminal count captured at grant
    logic [c_iw-1:0] last_q,  last_d;    // last requester that completed
    logic [c_iw-1:0] gidx_q,  gidx_d;    // index of the current owner

    // ------------------------------------------------------------------------
    // Arbitration helpers
    // ------------------------------------------------------------------------
    logic            w_arb_found;
    logic [c_iw-1:0] w_arb_idx;
    int              w_arb_cand;
    logic [N-1:0]    w_arb_limit;
    logic [R-1:0]    w_arb_onehot;
    logic            w_owner_req;

    // Scan candidates (last+1), (last+2), ... modulo R; first asserted wins.
    always_comb begin : arb_pick
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_arb_cand  = 0;
        for (int k = 1; k <= R; k++) begin
            w_arb_cand = int'(last_q) + k;
            if (w_arb_cand >= R) begin
                w_arb_cand = w_arb_cand - R;
            end
            for (int i = 0; i < R; i++) begin
                if (!w_arb_found && (w_arb_cand == i) && req[i]) begin
                    w_arb_found = 1'b1;
                    w_arb_idx   = c_iw'(i);
                end
            end
        end
    end

    // Decode the winner into its one-hot grant and its terminal count.
    always_comb begin : arb_load
        w_arb_limit  = '0;
        w_arb_onehot = '0;
        for (int i = 0; i < R; i++) begin
            if (w_arb_idx == c_iw'(i)) begin
                w_arb_limit     = limit[i*N +: N];
                w_arb_onehot[i] = 1'b1;
            end
        end
    end

    // The owner's request line; other requesters are ignored while busy.
    assign w_owner_req = |(req & gnt_q);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin : next_state
        state_d = state_q;
        gnt_d   = gnt_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = '0;
        lim_d   = lim_q;
        last_d  = last_q;
        gidx_d  = gidx_q;

        case (state_q)
            ST_IDLE: begin
                if (w_arb_found) begin
                    state_d = ST_RUN;
                    gnt_d   = w_arb_onehot;
                    gidx_d  = w_arb_idx;
                    lim_d   = w_arb_limit;
                    count_d = '0;
                    busy_d  = 1'b1;
                end
            end

            ST_RUN: begin
                // Abort is checked first so that it wins over reaching the
                // terminal count on the same edge.
                if (!w_owner_req) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b0;
                end else if (count_q == lim_q) begin
                    state_d = ST_DONE;
                    done_d  = gnt_q;
                end else begin
                    count_d = count_q + N'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                count_d = '0;
                busy_d  = 1'b0;
                last_d  = gidx_q;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                count_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin : regs
        if (clr) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            lim_q   <= '0;
            last_q  <= c_last_init;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lim_q   <= lim_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
        end
    end

    assign gnt   = gnt_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_counter_arbiter
// Purpose  : Self-checking bench for shared_counter_arbiter (N=4, R=3).
//            Vector table, directed corner sequences and a randomized run
//            compared against an interval-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_counter_arbiter;

    localparam int N = 4;
    localparam int R = 3;

    logic           clk;
    logic           clr;
    logic [R-1:0]   req;
    logic [R*N-1:0] limit;
    logic [R-1:0]   gnt;
    logic [N-1:0]   count;
    logic           busy;
    logic [R-1:0]   done;

    int total = 0;
    int bad   = 0;

    shared_counter_arbiter #(.N(N), .R(R)) dut (
        .clk   (clk),
        .clr   (clr),
        .req   (req),
        .limit (limit),
        .gnt   (gnt),
        .count (count),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: owner index (-1 = idle), edges since grant (t) and the
    // captured terminal count. Counter shows t until it reaches lim; t=lim+1
    // is the done cycle.
    // ------------------------------------------------------------------------
    int m_owner, m_t, m_lim, m_last;

    task automatic model_reset();
        m_owner = -1;
        m_t     = 0;
        m_lim   = 0;
        m_last  = R - 1;
    endtask

    task automatic model_step();
        int c;
        if (m_owner < 0) begin
            for (int j = 1; j <= R; j++) begin
                c = (m_last + j) % R;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_t     = 0;
                    m_lim   = int'(limit[c*N +: N]);
                end
            end
        end else if (m_t <= m_lim) begin
            if (!req[m_owner]) m_owner = -1;
            else               m_t     = m_t + 1;
        end else begin
            m_last  = m_owner;
            m_owner = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (clr) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [R-1:0] e_gnt;
        logic [N-1:0] e_cnt;
        logic [R-1:0] e_done;
        e_gnt  = (m_owner < 0) ? '0 : R'(1 << m_owner);
        e_cnt  = (m_owner < 0) ? '0 : N'((m_t > m_lim) ? m_lim : m_t);
        e_done = (m_owner >= 0 && m_t == m_lim + 1) ? e_gnt : '0;
        chk({tag, "_gnt"},   gnt,   e_gnt);
        chk({tag, "_count"}, count, e_cnt);
        chk({tag, "_busy"},  busy,  (m_owner >= 0));
        chk({tag, "_done"},  done,  e_done);
    endtask

    // Run until done is seen (bounded); report edges taken and count history.
    task automatic run_to_done(input int max_edges, output int edges,
                               output int max_cnt, output bit zero_mid);
        bit seen;
        edges = 0; max_cnt = 0; zero_mid = 1'b0; seen = 1'b0;
        while (!seen && edges < max_edges) begin
            tick();
            edges++;
            if (edges > 1 && count == '0) zero_mid = 1'b1;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (done != '0) seen = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------------
    // Vector table: inputs applied before an edge, outputs expected after it.
    // ------------------------------------------------------------------------
    typedef struct {
        logic           clr;
        logic [R-1:0]   req;
        logic [R*N-1:0] lim;
        logic [R-1:0]   gnt;
        logic [N-1:0]   cnt;
        logic           busy;
        logic [R-1:0]   dn;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic c, input logic [R-1:0] r, input logic [R*N-1:0] l,
                       input logic [R-1:0] g, input logic [N-1:0] cn,
                       input logic b, input logic [R-1:0] d);
        vec_t v;
        v.clr = c; v.req = r; v.lim = l; v.gnt = g; v.cnt = cn; v.busy = b; v.dn = d;
        tbl.push_back(v);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int edges, maxc, n;
        bit zmid;
        logic [R-1:0]   r;
        logic [R*N-1:0] lv;

        clr = 1'b1; req = '0; limit = '0;
        model_reset();

        // reset, then round robin with all limits = 1
        add(1, 3'b111, 12'h111, 3'b000, 4'd0, 0, 3'b000);
        add(0, 3'b111, 12'h111, 3'b001, 4'd0, 1, 3'b000);
        add(0, 3'b111, 12'h111, 3'b001, 4'd1, 1, 3'b000);
        add(0, 3'b111, 12'h111, 3'b001, 4'd1, 1, 3'b001);
        add(0, 3'b111, 12'h111, 3'b000, 4'd0, 0, 3'b000);
        add(0, 3'b111, 12'h111, 3'b010, 4'd0, 1, 3'b000);
        add(0, 3'b111, 12'h111, 3'b010, 4'd1, 1, 3'b000);
        add(0, 3'b111, 12'h111, 3'b010, 4'd1, 1, 3'b010);
        add(0, 3'b111, 12'h111, 3'b000, 4'd0, 0, 3'b000);
        add(0, 3'b111, 12'h111, 3'b100, 4'd0, 1, 3'b000);
        add(0, 3'b111, 12'h111, 3'b100, 4'd1, 1, 3'b000);
        add(0, 3'b111, 12'h111, 3'b100, 4'd1, 1, 3'b100);
        add(0, 3'b111, 12'h111, 3'b000, 4'd0, 0, 3'b000);
        add(0, 3'b111, 12'h111, 3'b001, 4'd0, 1, 3'b000);
        // drop req0 immediately: abort, no done
        add(0, 3'b000, 12'h111, 3'b000, 4'd0, 0, 3'b000);
        // single interval, requester 1 with limit 5
        add(0, 3'b010, 12'h050, 3'b010, 4'd0, 1, 3'b000);
        add(0, 3'b010, 12'h050, 3'b010, 4'd1, 1, 3'b000);
        add(0, 3'b010, 12'h050, 3'b010, 4'd2, 1, 3'b000);
        add(0, 3'b010, 12'h050, 3'b010, 4'd3, 1, 3'b000);
        add(0, 3'b010, 12'h050, 3'b010, 4'd4, 1, 3'b000);
        add(0, 3'b010, 12'h050, 3'b010, 4'd5, 1, 3'b000);
        add(0, 3'b010, 12'h050, 3'b010, 4'd5, 1, 3'b010);
        add(0, 3'b000, 12'h050, 3'b000, 4'd0, 0, 3'b000);
        add(0, 3'b000, 12'h050, 3'b000, 4'd0, 0, 3'b000);

        for (int i = 0; i < tbl.size(); i++) begin
            clr = tbl[i].clr; req = tbl[i].req; limit = tbl[i].lim;
            tick();
            chk($sformatf("vec%0d_gnt", i),   gnt,   tbl[i].gnt);
            chk($sformatf("vec%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("vec%0d_busy", i),  busy,  tbl[i].busy);
            chk($sformatf("vec%0d_done", i),  done,  tbl[i].dn);
        end

        // limit = 0: done after exactly 2 edges
        req = 3'b001; limit = 12'h000;
        run_to_done(40, edges, maxc, zmid);
        chk("lim0_edges", edges, 2);
        chk("lim0_done", done, 3'b001);
        req = '0; tick();
        chk("lim0_idle", gnt, 3'b000);

        // limit = 15: reaches all-ones, never wraps to 0 mid-interval
        req = 3'b001; limit = 12'h00F;
        run_to_done(40, edges, maxc, zmid);
        chk("limF_edges", edges, 17);
        chk("limF_maxcount", maxc, 15);
        chk("limF_nowrap", zmid, 0);
        chk("limF_done", done, 3'b001);
        chk("limF_count_at_done", count, 4'hF);
        req = '0; tick();

        // abort at count 3, then abort exactly at terminal count 6
        for (int a = 0; a < 2; a++) begin
            req = 3'b001; limit = 12'h006;
            tick();
            chk($sformatf("abort%0d_grant", a), gnt, 3'b001);
            n = 0;
            while (int'(count) != (a == 0 ? 3 : 6) && n < 20) begin
                tick(); n++;
            end
            chk($sformatf("abort%0d_reach", a), count, (a == 0 ? 3 : 6));
            req = '0; tick();
            chk($sformatf("abort%0d_gnt", a),   gnt,   3'b000);
            chk($sformatf("abort%0d_count", a), count, 4'd0);
            chk($sformatf("abort%0d_busy", a),  busy,  1'b0);
            chk($sformatf("abort%0d_done", a),  done,  3'b000);
            tick();
            chk($sformatf("abort%0d_nodone", a), done, 3'b000);
        end

        // asynchronous reset mid-interval, then arbitration restarts at 0
        req = 3'b001; limit = 12'h006;
        tick();
        n = 0;
        while (count != 4'd2 && n < 20) begin
            tick(); n++;
        end
        chk("midrst_reach", count, 4'd2);
        #1 clr = 1'b1;
        #1 model_reset();
        chk("midrst_gnt",   gnt,   3'b000);
        chk("midrst_count", count, 4'd0);
        chk("midrst_busy",  busy,  1'b0);
        chk("midrst_done",  done,  3'b000);
        #1 clr = 1'b0;
        req = 3'b110;
        tick();
        chk("midrst_first_gnt", gnt, 3'b010);

        // randomized run against the model
        for (int c = 0; c < 800; c++) begin
            r = req;
            for (int i = 0; i < R; i++) begin
                if (!r[i]) begin
                    if ($urandom_range(0, 3) == 0) r[i] = 1'b1;
                end else if (done[i] && $urandom_range(0, 1) == 0) begin
                    r[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    r[i] = 1'b0;
                end
            end
            for (int i = 0; i < R; i++) begin
                lv[i*N +: N] = ($urandom_range(0, 7) == 0) ? 4'hF : N'($urandom_range(0, 3));
            end
            req = r; limit = lv;
            tick();
            chk_model("rand");
            if ($urandom_range(0, 63) == 0) begin
                #1 clr = 1'b1;
                #1 model_reset();
                chk_model("rand_rst");
                #1 clr = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
